// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame-level constants,
// common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the UART receiver: edge counter, three mid-bit samples
// and a 2-of-3 majority voter.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_s,
  input  logic               start,
  input  logic               active,
  input  logic [PRESC_W-1:0] presc,
  output logic               bit_val,
  output logic               bit_end
);

  logic [PRESC_W-1:0] edge_cnt;
  logic [PRESC_W-1:0] half;
  logic [PRESC_W-1:0] last;
  logic               s0, s1, s2;

  assign half = presc >> 1;
  assign last = presc - PRESC_W'(1);

  // The detection cycle is edge_cnt=0 of the start bit, so counting resumes at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
    end else if (start) begin
      edge_cnt <= PRESC_W'(1);
    end else if (!active) begin
      edge_cnt <= '0;
    end else if (edge_cnt == last) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else if (active) begin
      if (edge_cnt == half - PRESC_W'(1)) s0 <= rx_s;
      if (edge_cnt == half)               s1 <= rx_s;
      if (edge_cnt == half + PRESC_W'(1)) s2 <= rx_s;
    end
  end

  assign bit_val = (s0 & s1) | (s0 & s2) | (s1 & s2);
  assign bit_end = active && (edge_cnt == last);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, start/data/parity/stop FSM and
// registered one-cycle result strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  rx_state_t             state, nxt;
  logic                  rx_m, rx_s;
  logic                  start_det;
  logic [PRESC_W-1:0]    presc_q;
  logic                  pen_q, ptype_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  last_bit;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_mis;
  logic                  bit_val, bit_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  assign start_det = (state == IDLE) && !rx_s;
  assign last_bit  = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign busy      = (state != IDLE);

  uart_rx_sampler #(
    .PRESC_W(PRESC_W)
  ) u_sampler (
    .clk    (clk),
    .rst    (rst),
    .rx_s   (rx_s),
    .start  (start_det),
    .active (busy),
    .presc  (presc_q),
    .bit_val(bit_val),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (!rx_s) nxt = START;
      START:   if (bit_end) nxt = (bit_val == START_BIT) ? DATA : IDLE;
      DATA:    if (bit_end && last_bit) nxt = pen_q ? PARITY : STOP;
      PARITY:  if (bit_end) nxt = STOP;
      STOP:    if (bit_end) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q    <= '0;
      pen_q      <= 1'b0;
      ptype_q    <= PAR_EVEN;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_mis    <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (start_det) begin
        presc_q <= prescale;
        pen_q   <= par_en;
        ptype_q <= par_type;
        bit_cnt <= '0;
        par_mis <= 1'b0;
      end
      case (state)
        DATA: if (bit_end) begin
          shreg   <= {bit_val, shreg[DATA_WIDTH-1:1]};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        PARITY: if (bit_end) par_mis <= (bit_val != (^shreg ^ ptype_q));
        STOP: if (bit_end) begin
          stp_err <= (bit_val != STOP_BIT);
          par_err <= par_mis;
          if (bit_val == STOP_BIT && !par_mis) begin
            data_valid <= 1'b1;
            p_data     <= shreg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected strobes,
// a negedge monitor pops and compares them, including the strobe cycle.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_type = 1'b0;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err, busy;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    int unsigned cyc;
    logic        dv;
    logic        pe;
    logic        se;
    logic [7:0]  pd;
  } exp_t;

  exp_t q[$];

  uart_rx #(
    .DATA_WIDTH(8),
    .PRESC_W   (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .prescale  (prescale),
    .par_en    (par_en),
    .par_type  (par_type),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the queue, in the expected cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (data_valid || par_err || stp_err) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: dv=%b pe=%b se=%b expected none (cycle %0d)",
                   data_valid, par_err, stp_err, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("strobe_cycle", cyc, e.cyc);
          check("data_valid", {31'b0, data_valid}, {31'b0, e.dv});
          check("par_err", {31'b0, par_err}, {31'b0, e.pe});
          check("stp_err", {31'b0, stp_err}, {31'b0, e.se});
          check("p_data", {24'b0, p_data}, {24'b0, e.pd});
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_strobe: no strobe by cycle %0d, expected at cycle %0d", cyc, e.cyc);
      end
    end
  end

  task automatic hold(input int p);
    repeat (p) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int p, input logic pen, input logic pt,
                      input logic pbit, input logic stopb,
                      input logic edv, input logic epe, input logic ese, input logic [7:0] epd);
    exp_t e;
    prescale = 6'(p);
    par_en   = pen;
    par_type = pt;
    e.cyc = cyc + 2 + (pen ? 11 : 10) * p;
    e.dv  = edv;
    e.pe  = epe;
    e.se  = ese;
    e.pd  = epd;
    q.push_back(e);
    rx_in = 1'b0;
    hold(p);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      hold(p);
    end
    if (pen) begin
      rx_in = pbit;
      hold(p);
    end
    rx_in = stopb;
    hold(p);
    rx_in = 1'b1;
  endtask

  initial begin
    logic [7:0] abort_byte;
    abort_byte = 8'h5A;
    #12;
    check("rst_p_data", {24'b0, p_data}, 32'h0);
    check("rst_data_valid", {31'b0, data_valid}, 32'h0);
    check("rst_par_err", {31'b0, par_err}, 32'h0);
    check("rst_stp_err", {31'b0, stp_err}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    hold(5);

    send(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
    hold(5);
    // 0x3C has four ones: even parity bit 0
    send(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
    hold(5);
    // 0x01 with odd parity needs bit 0; sending 1 is a mismatch
    send(8'h01, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C);
    hold(5);
    send(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C);
    hold(20);
    send(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12);
    hold(10);

    prescale = 6'd16;
    rx_in = 1'b0;
    hold(3);
    rx_in = 1'b1;
    hold(2);
    check("glitch_busy_high", {31'b0, busy}, 32'h1);
    hold(20);
    check("glitch_busy_low", {31'b0, busy}, 32'h0);
    hold(10);

    prescale = 6'd8;
    par_en   = 1'b0;
    rx_in    = 1'b0;
    hold(8);
    for (int i = 0; i < 3; i++) begin
      rx_in = abort_byte[i];
      hold(8);
    end
    check("abort_busy_before", {31'b0, busy}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_p_data", {24'b0, p_data}, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_data_valid", {31'b0, data_valid}, 32'h0);
    rx_in = 1'b1;
    @(posedge clk); #1;
    hold(2);
    rst = 1'b1;
    hold(5);
    send(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    hold(10);

    // Zero-gap pair: second start edge lands on the first frame's strobe cycle
    send(8'h00, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    send(8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);

    for (int i = 0; i < 2000 && q.size() > 0; i++) @(posedge clk);
    hold(20);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected strobes outstanding, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's UART transmitter, sharing its frame format: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit.
- Oversamples the serial line with the system clock: each bit lasts `prescale` clock cycles.
- Synchronises the line, rejects start-bit glitches, majority-votes each bit, checks parity and stop, then presents one parallel byte with a one-cycle valid strobe.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESC_W, 6, width of the `prescale` input.

Ports:
- clk  input  1  system/oversampling clock.
- rst  input  1  asynchronous reset, active-low.
- rx_in  input  1  serial line, idle high, asynchronous to clk.
- prescale  input  PRESC_W  clocks per bit; legal values 8, 16, 32. Sampled at start detection.
- par_en  input  1  1 = parity bit present. Sampled at start detection.
- par_type  input  1  0 = even, 1 = odd. Sampled at start detection.
- p_data  output  DATA_WIDTH  received byte; updated only with data_valid.
- data_valid  output  1  one-cycle pulse; frame received with no error.
- par_err  output  1  one-cycle pulse; parity mismatch.
- stp_err  output  1  one-cycle pulse; stop bit sampled 0.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE.
  - p_data=0; data_valid, par_err, stp_err and busy all 0.
  - Synchroniser flops reset to 1; counters reset to 0.
  - Reset mid-frame abandons the frame with no strobes; the first start is detected after rst rises.
- Synchroniser: 2 flops, rx_in -> rx_s. All timing below is on rx_s, which lags rx_in by 2 cycles.
- Bit timing: edge_cnt runs 0..prescale-1 within each bit, and bit_cnt counts data bits.
- The detection cycle (IDLE with rx_s=0) is edge_cnt=0 of the start bit.
- Sample points: rx_s is captured at edge_cnt = prescale/2-1, prescale/2 and prescale/2+1. The bit value is the 2-of-3 majority, valid from edge_cnt = prescale/2+2.
- FSM states (enum in package): IDLE, START, DATA, PARITY, STOP.
  - IDLE: on rx_s=0, latch prescale/par_en/par_type, clear counters, go to START.
  - START: at bit end (edge_cnt=prescale-1), go to DATA if the majority is 0. If the majority is 1 (glitch), return to IDLE with no strobes.
  - DATA: shift the majority bit into a shift register LSB-first at each bit end. After DATA_WIDTH bits, go to PARITY if par_en, else STOP.
  - PARITY: compute the expected bit, XOR of data ^ par_type. Record a mismatch flag. At bit end go to STOP.
  - STOP: at bit end go to IDLE and register the result strobes:
    - Stop majority=0 -> stp_err=1.
    - Parity mismatch -> par_err=1.
    - Both errors may assert together.
    - data_valid=1 and p_data=shift register only if neither error occurs.
- Latency: frame length F = 10 bits without parity, 11 with. Strobes are high exactly in cycle (rx_in falling edge + 2 + F*prescale), for one cycle.
- Back-to-back frames: IDLE is re-entered on the strobe cycle, and a start edge present that cycle is detected immediately. Frames with zero idle gap are received without loss.
- Inputs are ignored mid-frame: prescale/par_en/par_type changes during a frame do not affect it.
- Illegal prescale (not 8/16/32) gives undefined data but must not hang: the FSM always returns to IDLE.

Decomposition:
- Package uart_pkg:
  - typedef enum rx_state_t.
  - localparams PAR_EVEN=0, PAR_ODD=1, START_BIT=0, STOP_BIT=1.
  - Shared with the transmitter.
- Sub-module uart_rx_sampler:
  - Holds edge_cnt, the 3 sample flops and the majority voter.
  - Outputs bit_val and bit_end to the FSM in uart_rx.

Test Plan:
- prescale=8, par_en=0, send 0xA5 -> data_valid single pulse with p_data=0xA5 at fall+2+80; par_err=stp_err=0.
- prescale=16, par_en=1, par_type=0 (even), send 0x3C with correct parity 0 -> data_valid, p_data=0x3C at fall+2+176.
- prescale=8, odd parity, send 0x01 with parity bit 1 (wrong) -> par_err pulse, data_valid=0, p_data keeps its previous value.
- prescale=8, send 0x55 with stop bit driven 0 -> stp_err pulse, no data_valid; then an idle line followed by 0x12 -> 0x12 received normally.
- Glitch test: rx_in low for 3 cycles at prescale=16 -> busy rises then falls, no strobes. Also drop rst mid-DATA -> all outputs 0 immediately, and the next frame 0xFF is received correctly.
- Two frames 0x00 then 0xFF with zero gap at prescale=32 -> two data_valid pulses exactly 320 cycles apart with correct data.
